peripheral_apb4_ahb4_master: RTL
================================

// Module: peripheral_apb4_ahb4_master
// PURPOSE
//  APB4 slave in, AHB-Lite (AHB4) master out. The reverse of the AHB4->APB4 bridge.
//  Lets an APB-side agent (debug/DMA config port) issue single transfers onto AHB memory/peripherals.
//  Each APB access becomes exactly one AHB SINGLE/NONSEQ transfer. One clock domain.
// PARAMETERS
//  PADDR_SIZE  8      APB address width
//  PDATA_SIZE  32     APB/AHB data width; HDATA_SIZE==PDATA_SIZE; legal 32 or 64
//  HADDR_SIZE  32     AHB address width; must be >= PADDR_SIZE
//  AHB_BASE    'h0    HADDR[HADDR_SIZE-1:PADDR_SIZE] constant for every transfer
//  TIMEOUT     255    HREADY-low cycles before abort (PERIPHERAL_APB4_AHB4_TIMEOUT_EN only)
// PORTS
//  HCLK       in   1             clock, rising edge
//  HRESET     in   1             reset, asynchronous, active-high
//  PSEL       in   1             APB select
//  PENABLE    in   1             APB access phase
//  PPROT      in   3             APB protection
//  PWRITE     in   1             1=write
//  PSTRB      in   PDATA_SIZE/8  write byte strobes
//  PADDR      in   PADDR_SIZE    byte address
//  PWDATA     in   PDATA_SIZE    write data
//  PRDATA     out  PDATA_SIZE    read data, valid with PREADY
//  PREADY     out  1             access complete
//  PSLVERR    out  1             error, valid with PREADY
//  HADDR/HWRITE/HSIZE[3]/HBURST[3]/HPROT[4]/HTRANS[2]/HMASTLOCK  out   AHB address phase
//  HWDATA     out  PDATA_SIZE    AHB write data
//  HRDATA     in   PDATA_SIZE    AHB read data
//  HREADY     in   1             AHB ready
//  HRESP      in   1             AHB error
// BEHAVIOUR
//  Reset: all outputs 0 (HTRANS=IDLE, PREADY=0, PSLVERR=0, PRDATA=0). FSM goes to IDLE immediately, also mid-transfer.
//  FSM IDLE->ADDR->DATA->DONE->IDLE, plus ERR2 and (with the macro) DRAIN.
//  IDLE: on PSEL&~PENABLE, register PADDR/PWDATA/PWRITE/PSTRB/PPROT and decode strobes.
//    Illegal strobes go straight to DONE with PSLVERR=1 and no AHB transfer.
//  Strobe decode, writes only: the set strobes must be one contiguous, naturally aligned power-of-2 run.
//    HSIZE=log2(run bytes). HADDR[low]=run offset (ignores PADDR low bits).
//    PSTRB==0 on a write is illegal. Reads: HSIZE=log2(PDATA_SIZE/8) and PSTRB is ignored.
//  ADDR: HTRANS=NONSEQ(2'b10), HBURST=SINGLE, HMASTLOCK=0.
//    HADDR={AHB_BASE, PADDR adjusted}.
//    HPROT={2'b00, PPROT[0], ~PPROT[2]}.
//    Holds until HREADY=1, then moves to DATA with HTRANS=IDLE.
//  DATA: HWDATA driven from the register. Waits while HREADY=0&HRESP=0.
//    HREADY=1&HRESP=0: capture HRDATA on reads, go to DONE.
//    HRESP=1&HREADY=0: go to ERR2. ERR2 waits for HREADY=1, then DONE with PSLVERR=1.
//  DONE: PREADY=1 for exactly one cycle, PSLVERR per result, PRDATA valid. Then IDLE.
//  Zero-wait AHB latency: setup + 3 access cycles (ADDR, DATA, DONE).
//  PRDATA keeps its last value outside DONE. It is 0 after a write or an error.
//  PSEL dropped before DONE (protocol violation): the AHB transfer still completes and the result is discarded.
//    PREADY is not pulsed.
//  A new APB setup is accepted only in IDLE.
// CONFIGURATION
//  PERIPHERAL_APB4_AHB4_TIMEOUT_EN defined:
//    Counter runs in ADDR/DATA while HREADY=0 and clears on HREADY=1.
//    At TIMEOUT it issues DONE with PSLVERR=1, then enters DRAIN.
//    DRAIN drives HTRANS=IDLE until HREADY=1, then returns to IDLE. No new setup is accepted in DRAIN.
//  Undefined: no counter and no DRAIN state; the block waits on HREADY forever.
// STRUCTURE
//  peripheral_apb4_ahb4_pkg: state enum; HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_B8/B16/B32/B64 constants.
//  Sub-module peripheral_apb4_ahb4_strb_decode: combinational PSTRB -> {legal, hsize, byte offset}.
// TESTING
//  Write 0xDEADBEEF, PSTRB=4'hF, PADDR=0x10, zero-wait AHB -> one NONSEQ, HSIZE=2, HADDR=AHB_BASE|0x10, PREADY 3rd access cycle.
//  Read, HRDATA=0x12345678, HREADY low 2 cycles in DATA -> PRDATA=0x12345678 with PREADY on 5th access cycle, PSLVERR=0.
//  Write PSTRB=4'b1100, PADDR=0x20 -> HSIZE=1, HADDR low=0x22. PSTRB=4'b0110 -> PSLVERR=1, no HTRANS!=IDLE ever.
//  Two-cycle HRESP=1 on read -> PREADY=1, PSLVERR=1, PRDATA=0.
//  HRESET pulse while in DATA -> HTRANS=IDLE and PREADY=0 same cycle; the next access completes normally.
//  Macro on, TIMEOUT=4, HREADY stuck low -> PSLVERR after 4 cycles; the next setup is held off until HREADY=1.

Source files
------------

// File: rtl/peripheral_apb4_ahb4_pkg.sv
// ============================================================================
//  Module      : peripheral_apb4_ahb4_pkg
//  Description : Shared types and AHB encodings for the APB4 -> AHB-Lite
//                master bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package peripheral_apb4_ahb4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ERR2  = 3'd3,
        ST_DONE  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_B8      = 3'd0;
    localparam logic [2:0] HSIZE_B16     = 3'd1;
    localparam logic [2:0] HSIZE_B32     = 3'd2;
    localparam logic [2:0] HSIZE_B64     = 3'd3;

    // Map log2(transfer bytes) onto the HSIZE encoding.
    function automatic logic [2:0] size_code(input int log2_bytes);
        case (log2_bytes)
            0:       return HSIZE_B8;
            1:       return HSIZE_B16;
            2:       return HSIZE_B32;
            default: return HSIZE_B64;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/peripheral_apb4_ahb4_strb_decode.sv
// ============================================================================
//  Module      : peripheral_apb4_ahb4_strb_decode
//  Description : Combinational PSTRB decode. A strobe pattern is legal when it
//                is a single contiguous, naturally aligned power-of-two run of
//                bytes; the run gives the AHB HSIZE and byte offset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_apb4_ahb4_strb_decode
    import peripheral_apb4_ahb4_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic [NBYTES-1:0]         i_strb,
    output logic                      o_legal,
    output logic [2:0]                o_hsize,
    output logic [$clog2(NBYTES)-1:0] o_offset
);

    localparam int c_OW = $clog2(NBYTES);

    logic [NBYTES-1:0] w_mask;

    // Compare the strobes against every aligned run of every legal size.
    always_comb begin
        o_legal  = 1'b0;
        o_hsize  = '0;
        o_offset = '0;
        w_mask   = '0;
        for (int s = 0; s <= c_OW; s++) begin
            for (int o = 0; o < NBYTES; o++) begin
                if ((o % (1 << s)) == 0) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        w_mask[b] = (b >= o) && (b < o + (1 << s));
                    end
                    if (i_strb == w_mask) begin
                        o_legal  = 1'b1;
                        o_hsize  = size_code(s);
                        o_offset = o[c_OW-1:0];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/peripheral_apb4_ahb4_master.sv
// ============================================================================
//  Module      : peripheral_apb4_ahb4_master
//  Description : APB4 slave to AHB-Lite master bridge. Each APB access is
//                issued as one AHB SINGLE/NONSEQ transfer.
//                Optional macro PERIPHERAL_APB4_AHB4_TIMEOUT_EN adds an
//                HREADY-low timeout with a DRAIN recovery state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_apb4_ahb4_master
    import peripheral_apb4_ahb4_pkg::*;
#(
    parameter int                    PADDR_SIZE = 8,
    parameter int                    PDATA_SIZE = 32,
    parameter int                    HADDR_SIZE = 32,
    parameter logic [HADDR_SIZE-1:0] AHB_BASE   = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [2:0]              PPROT,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [HADDR_SIZE-1:0]   HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HMASTLOCK,
    output logic [PDATA_SIZE-1:0]   HWDATA,
    input  logic [PDATA_SIZE-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    localparam int         c_NBYTES     = PDATA_SIZE / 8;
    localparam int         c_OW         = $clog2(c_NBYTES);
    localparam logic [2:0] c_HSIZE_WORD = size_code(c_OW);

    state_t                  r_state, w_state_nxt;
    logic [PADDR_SIZE-1:0]   r_addr;
    logic [PDATA_SIZE-1:0]   r_wdata, r_rdata;
    logic                    r_write, r_err, r_lost;
    logic [2:0]              r_hsize;
    logic [3:0]              r_hprot;

    logic                    w_dec_legal;
    logic [2:0]              w_dec_hsize;
    logic [c_OW-1:0]         w_dec_offset;
    logic                    w_load, w_finish, w_fin_err, w_fin_rd;
    logic                    w_lost, w_timeout;

    // PPROT[1] has no AHB counterpart; PADDR low bits come from the strobe run.
    logic w_unused_ok;
    assign w_unused_ok = ^{PPROT[1], PADDR[c_OW-1:0]};

    peripheral_apb4_ahb4_strb_decode #(
        .NBYTES (c_NBYTES)
    ) u_strb_decode (
        .i_strb   (PSTRB),
        .o_legal  (w_dec_legal),
        .o_hsize  (w_dec_hsize),
        .o_offset (w_dec_offset)
    );

    // A dropped PSEL during the AHB transfer means its result is discarded.
    assign w_lost = (r_state != ST_IDLE) && (r_lost || !PSEL);

`ifdef PERIPHERAL_APB4_AHB4_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT + 1);
    logic [c_CW-1:0] r_cnt;
    logic            r_to;

    assign w_timeout = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && !HREADY
                       && (r_cnt == c_CW'(TIMEOUT - 1));

    // HREADY-low cycle counter for the address and data phases.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && !HREADY) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_finish) begin
                r_to <= w_timeout;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and completion control.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_rd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_load = 1'b1;
                    if (!PWRITE || w_dec_legal) begin
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_finish  = 1'b1;
                        w_fin_err = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HRESP) begin
                    if (HREADY) begin
                        w_finish  = 1'b1;
                        w_fin_err = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR2;
                    end
                end else if (HREADY) begin
                    w_finish = 1'b1;
                    w_fin_rd = !r_write;
                end
            end
            ST_ERR2: begin
                if (HREADY) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
`ifdef PERIPHERAL_APB4_AHB4_TIMEOUT_EN
            ST_DONE:  w_state_nxt = r_to ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (HREADY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`else
            ST_DONE:  w_state_nxt = ST_IDLE;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_finish  = 1'b1;
            w_fin_err = 1'b1;
            w_fin_rd  = 1'b0;
        end
        if (w_finish) begin
            if (!w_lost) begin
                w_state_nxt = ST_DONE;
            end else if (w_timeout) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Transfer attributes captured at setup; result captured on completion.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_hsize <= '0;
            r_hprot <= '0;
            r_lost  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_load) begin
                r_addr  <= {PADDR[PADDR_SIZE-1:c_OW], (PWRITE ? w_dec_offset : {c_OW{1'b0}})};
                r_wdata <= PWDATA;
                r_write <= PWRITE;
                r_hsize <= PWRITE ? w_dec_hsize : c_HSIZE_WORD;
                r_hprot <= {2'b00, PPROT[0], ~PPROT[2]};
            end
            if (w_load) begin
                r_lost <= 1'b0;
            end else if (((r_state == ST_ADDR) || (r_state == ST_DATA) ||
                          (r_state == ST_ERR2)) && !PSEL) begin
                r_lost <= 1'b1;
            end
            if (w_finish && !w_lost) begin
                r_err   <= w_fin_err;
                r_rdata <= w_fin_rd ? HRDATA : '0;
            end
        end
    end

    assign PREADY    = (r_state == ST_DONE);
    assign PSLVERR   = (r_state == ST_DONE) && r_err;
    assign PRDATA    = r_rdata;
    assign HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = (r_state == ST_ADDR) ? {AHB_BASE[HADDR_SIZE-1:PADDR_SIZE], r_addr} : '0;
    assign HWRITE    = (r_state == ST_ADDR) && r_write;
    assign HSIZE     = (r_state == ST_ADDR) ? r_hsize : 3'b000;
    assign HPROT     = (r_state == ST_ADDR) ? r_hprot : 4'b0000;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = ((r_state == ST_DATA) && r_write) ? r_wdata : '0;

endmodule

`default_nettype wire
